// File: rtl/tensor_core_burst_controller_pkg.sv
// Shared constants, select/direction encodings and FSM state type for the tensor core burst path.
package tensor_core_pkg;

   localparam int DATA_WIDTH   = 8;
   localparam int MATRIX_DIM   = 3;
   localparam int MATRIX_ELEMS = MATRIX_DIM * MATRIX_DIM;
   localparam int ADDR_WIDTH   = 5;
   localparam int IDX_WIDTH    = 5;

   localparam logic [ADDR_WIDTH-1:0] MATRIX2_BASE = 5'd9;

   typedef enum logic [1:0] {
      SEL_MATRIX1 = 2'b00,
      SEL_MATRIX2 = 2'b01,
      SEL_BOTH    = 2'b10,
      SEL_ILLEGAL = 2'b11
   } burst_select_t;

   localparam logic DIR_READ  = 1'b0;
   localparam logic DIR_WRITE = 1'b1;

   typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} burst_state_t;

   // Terminal index of a burst; compared before the counter could reach the count.
   function automatic logic [IDX_WIDTH-1:0] last_index(input burst_select_t sel);
      return (sel == SEL_BOTH) ? IDX_WIDTH'(2 * MATRIX_ELEMS - 1) : IDX_WIDTH'(MATRIX_ELEMS - 1);
   endfunction

endpackage

// File: rtl/tensor_core_burst_controller_if.sv
// Command, stream and register-file port bundle of the tensor core burst controller.
interface tensor_core_burst_if
   import tensor_core_pkg::*;
   ();

   logic                  cmd_valid_in;
   logic                  cmd_ready_out;
   logic [1:0]            cmd_matrix_select_in;
   logic                  cmd_write_in;
   logic [DATA_WIDTH-1:0] wr_data_in;
   logic                  wr_valid_in;
   logic                  wr_ready_out;
   logic [DATA_WIDTH-1:0] rd_data_out;
   logic                  rd_valid_out;
   logic                  rd_ready_in;
   logic                  rf_write_enable_out;
   logic [ADDR_WIDTH-1:0] rf_write_address_out;
   logic [DATA_WIDTH-1:0] rf_write_data_out;
   logic [ADDR_WIDTH-1:0] rf_read_address_out;
   logic [DATA_WIDTH-1:0] rf_read_data_in;
   logic                  tensor_core_busy_in;
   logic                  busy_out;
   logic                  done_out;
   logic                  error_out;

   modport master (
      output cmd_valid_in, cmd_matrix_select_in, cmd_write_in,
      output wr_data_in, wr_valid_in, rd_ready_in, rf_read_data_in, tensor_core_busy_in,
      input  cmd_ready_out, wr_ready_out, rd_data_out, rd_valid_out,
      input  rf_write_enable_out, rf_write_address_out, rf_write_data_out, rf_read_address_out,
      input  busy_out, done_out, error_out
   );

   modport slave (
      input  cmd_valid_in, cmd_matrix_select_in, cmd_write_in,
      input  wr_data_in, wr_valid_in, rd_ready_in, rf_read_data_in, tensor_core_busy_in,
      output cmd_ready_out, wr_ready_out, rd_data_out, rd_valid_out,
      output rf_write_enable_out, rf_write_address_out, rf_write_data_out, rf_read_address_out,
      output busy_out, done_out, error_out
   );

endinterface

// File: rtl/tensor_core_burst_controller_addr_gen.sv
// Element index counter and register-file address generation for burst transfers.
// Optional BURST_TRANSPOSE_EN selects column-major streaming via per-matrix row/col counters.
module burst_address_generator
   import tensor_core_pkg::*;
(
   input  logic                  clock_in,
   input  logic                  reset_in,
   input  logic                  clear_in,
   input  logic                  advance_in,
   input  burst_select_t         select_in,
   output logic                  last_out,
   output logic [ADDR_WIDTH-1:0] address_out
);

   logic [IDX_WIDTH-1:0] index_q;

   assign last_out = (index_q == last_index(select_in));

   always_ff @(posedge clock_in or posedge reset_in) begin
      if (reset_in) begin
         index_q <= '0;
      end else if (clear_in || (advance_in && last_out)) begin
         index_q <= '0;
      end else if (advance_in) begin
         index_q <= index_q + 1'b1;
      end
   end

`ifdef BURST_TRANSPOSE_EN
   localparam int RC_WIDTH = $clog2(MATRIX_DIM);

   logic [RC_WIDTH-1:0]   row_q;
   logic [RC_WIDTH-1:0]   col_q;
   logic                  second_matrix;
   logic [ADDR_WIDTH-1:0] base;

   assign second_matrix = (select_in == SEL_BOTH) && (index_q >= IDX_WIDTH'(MATRIX_ELEMS));
   assign base          = ((select_in == SEL_MATRIX2) || second_matrix) ? MATRIX2_BASE : '0;

   // Row advances fastest; both counters wrap together at every matrix boundary.
   always_ff @(posedge clock_in or posedge reset_in) begin
      if (reset_in) begin
         row_q <= '0;
         col_q <= '0;
      end else if (clear_in || (advance_in && last_out)) begin
         row_q <= '0;
         col_q <= '0;
      end else if (advance_in) begin
         if (row_q == RC_WIDTH'(MATRIX_DIM - 1)) begin
            row_q <= '0;
            col_q <= (col_q == RC_WIDTH'(MATRIX_DIM - 1)) ? '0 : col_q + 1'b1;
         end else begin
            row_q <= row_q + 1'b1;
         end
      end
   end

   assign address_out = base + ADDR_WIDTH'(row_q) * ADDR_WIDTH'(MATRIX_DIM) + ADDR_WIDTH'(col_q);
`else
   // Select 10 runs straight through 0..17, so only matrix2 alone needs an offset.
   assign address_out = ((select_in == SEL_MATRIX2) ? MATRIX2_BASE : '0) + ADDR_WIDTH'(index_q);
`endif

endmodule

// File: rtl/tensor_core_burst_controller.sv
// Burst sequencer between the 8-bit stream port and the tensor core register file.
// Build option BURST_TRANSPOSE_EN enables column-major element ordering in the address generator.
//
//   state | meaning
//   IDLE  | ready for a command, no register-file traffic
//   WRITE | stream-in: each accepted element written to the register file
//   READ  | stream-out: register-file element offered until consumed
//   DONE  | one-cycle completion pulse (error pulse too for illegal select)
module tensor_core_burst_controller
   import tensor_core_pkg::*;
(
   input  logic         clock_in,
   input  logic         reset_in,
   tensor_core_burst_if.slave bus
);

   burst_state_t          state;
   burst_select_t         select_q;
   logic                  done_q;
   logic                  error_q;
   logic                  accept;
   logic                  wr_ready;
   logic                  rd_valid;
   logic                  wr_xfer;
   logic                  rd_xfer;
   logic                  last;
   logic [ADDR_WIDTH-1:0] address;

   assign accept   = (state == IDLE) && bus.cmd_valid_in;
   assign wr_ready = (state == WRITE) && !bus.tensor_core_busy_in;
   assign rd_valid = (state == READ) && !bus.tensor_core_busy_in;
   assign wr_xfer  = wr_ready && bus.wr_valid_in;
   assign rd_xfer  = rd_valid && bus.rd_ready_in;

   burst_address_generator u_addr_gen (
      .clock_in    (clock_in),
      .reset_in    (reset_in),
      .clear_in    (accept),
      .advance_in  (wr_xfer || rd_xfer),
      .select_in   (select_q),
      .last_out    (last),
      .address_out (address)
   );

   always_ff @(posedge clock_in or posedge reset_in) begin
      if (reset_in) begin
         state    <= IDLE;
         select_q <= SEL_MATRIX1;
         done_q   <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         done_q  <= 1'b0;
         error_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.cmd_valid_in) begin
                  select_q <= burst_select_t'(bus.cmd_matrix_select_in);
                  if (burst_select_t'(bus.cmd_matrix_select_in) == SEL_ILLEGAL) begin
                     state   <= DONE;
                     done_q  <= 1'b1;
                     error_q <= 1'b1;
                  end else if (bus.cmd_write_in == DIR_WRITE) begin
                     state <= WRITE;
                  end else begin
                     state <= READ;
                  end
               end
            end
            WRITE: begin
               if (wr_xfer && last) begin
                  state  <= DONE;
                  done_q <= 1'b1;
               end
            end
            READ: begin
               if (rd_xfer && last) begin
                  state  <= DONE;
                  done_q <= 1'b1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.cmd_ready_out        = (state == IDLE);
   assign bus.busy_out             = (state != IDLE);
   assign bus.done_out             = done_q;
   assign bus.error_out            = error_q;
   assign bus.wr_ready_out         = wr_ready;
   assign bus.rd_valid_out         = rd_valid;
   assign bus.rd_data_out          = bus.rf_read_data_in;
   assign bus.rf_write_enable_out  = wr_xfer;
   assign bus.rf_write_data_out    = bus.wr_data_in;
   assign bus.rf_write_address_out = (state == WRITE) ? address : '0;
   assign bus.rf_read_address_out  = (state == READ) ? address : '0;

endmodule

// File: tb/tb_tensor_core_burst_controller.sv
// Directed and randomized bench for tensor_core_burst_controller with a behavioural element-to-address model.
module tb_tensor_core_burst_controller;

   logic clock_in = 1'b0;
   logic reset_in;
   always #5 clock_in = ~clock_in;

   tensor_core_burst_if bus ();

   tensor_core_burst_controller dut (
      .clock_in (clock_in),
      .reset_in (reset_in),
      .bus      (bus)
   );

   int vectors     = 0;
   int miscompares = 0;

   logic [7:0] rf_mem [0:31];
   assign bus.rf_read_data_in = rf_mem[bus.rf_read_address_out];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int elem_count(input int sel);
      return (sel == 2) ? 18 : 9;
   endfunction

   // Element k of a burst -> register number, straight from the matrix layout.
   function automatic int exp_addr(input int sel, input int k);
      int m, j, base;
      m    = (sel == 2) ? k / 9 : 0;
      j    = (sel == 2) ? k % 9 : k;
      base = (sel == 1 || m == 1) ? 9 : 0;
`ifdef BURST_TRANSPOSE_EN
      return base + (j % 3) * 3 + j / 3;
`else
      return base + j;
`endif
   endfunction

   task automatic next_cycle();
      @(posedge clock_in);
      @(negedge clock_in);
   endtask

   task automatic issue(input int sel, input bit wr);
      bus.cmd_valid_in         = 1'b1;
      bus.cmd_matrix_select_in = 2'(sel);
      bus.cmd_write_in         = wr;
      #1;
      check("cmd_ready_idle", bus.cmd_ready_out, 1);
      next_cycle();
      bus.cmd_valid_in = 1'b0;
   endtask

   task automatic finish_burst(input bit err);
      #1;
      check("done_pulse", bus.done_out, 1);
      check("error_flag", bus.error_out, err);
      check("we_in_done", bus.rf_write_enable_out, 0);
      check("busy_in_done", bus.busy_out, 1);
      next_cycle();
      #1;
      check("done_clear", bus.done_out, 0);
      check("error_clear", bus.error_out, 0);
      check("cmd_ready_after", bus.cmd_ready_out, 1);
      check("busy_after", bus.busy_out, 0);
   endtask

   // mode 0: random valid/busy/cmd noise; 1: back-to-back; 2: busy on burst cycles 4-6
   task automatic write_burst(input int sel, input int mode, input int first_data);
      int k = 0;
      int cyc = 0;
      int n = elem_count(sel);
      int a;
      bit busy, valid;
      logic [7:0] d;
      issue(sel, 1'b1);
      while (k < n && cyc < 400) begin
         case (mode)
            1:       begin busy = 1'b0; valid = 1'b1; end
            2:       begin busy = (cyc >= 3 && cyc <= 5); valid = 1'b1; end
            default: begin busy = ($urandom_range(0, 3) == 0); valid = ($urandom_range(0, 3) != 0); end
         endcase
         d = (mode == 0) ? 8'($urandom) : 8'(first_data + k);
         bus.tensor_core_busy_in  = busy;
         bus.wr_valid_in          = valid;
         bus.wr_data_in           = d;
         bus.cmd_valid_in         = (mode == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
         bus.cmd_matrix_select_in = 2'($urandom);
         bus.cmd_write_in         = 1'($urandom);
         #1;
         check("wr_ready", bus.wr_ready_out, !busy);
         check("rf_we", bus.rf_write_enable_out, valid && !busy);
         check("cmd_ready_busy", bus.cmd_ready_out, 0);
         check("done_mid_burst", bus.done_out, 0);
         if (valid && !busy) begin
            a = exp_addr(sel, k);
            check("wr_addr", bus.rf_write_address_out, 32'(a));
            check("wr_data", bus.rf_write_data_out, d);
            rf_mem[a] = d;
            k++;
         end
         next_cycle();
         cyc++;
      end
      check("write_count", k, n);
      if (mode == 1) check("b2b_latency", cyc, n);
      if (mode == 2) check("stall_latency", cyc, n + 3);
      bus.wr_valid_in         = 1'b0;
      bus.tensor_core_busy_in = 1'b0;
      bus.cmd_valid_in        = 1'b0;
      finish_burst(1'b0);
   endtask

   // mode 0: random ready/busy; 1: ready toggling 1,0,1,... with no stalls
   task automatic read_burst(input int sel, input int mode);
      int k = 0;
      int cyc = 0;
      int n = elem_count(sel);
      int a;
      bit busy, ready;
      issue(sel, 1'b0);
      while (k < n && cyc < 400) begin
         if (mode == 1) begin
            busy  = 1'b0;
            ready = (cyc % 2 == 0);
         end else begin
            busy  = ($urandom_range(0, 3) == 0);
            ready = ($urandom_range(0, 2) != 0);
         end
         bus.tensor_core_busy_in = busy;
         bus.rd_ready_in         = ready;
         bus.cmd_valid_in        = (mode == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
         #1;
         a = exp_addr(sel, k);
         check("rd_valid", bus.rd_valid_out, !busy);
         check("rd_addr", bus.rf_read_address_out, 32'(a));
         check("rd_data", bus.rd_data_out, rf_mem[a]);
         check("we_in_read", bus.rf_write_enable_out, 0);
         check("done_mid_read", bus.done_out, 0);
         if (!busy && ready) k++;
         next_cycle();
         cyc++;
      end
      check("read_count", k, n);
      if (mode == 1) check("toggle_latency", cyc, 2 * n - 1);
      bus.rd_ready_in         = 1'b0;
      bus.tensor_core_busy_in = 1'b0;
      bus.cmd_valid_in        = 1'b0;
      finish_burst(1'b0);
   endtask

   task automatic illegal_burst();
      issue(3, 1'($urandom));
      finish_burst(1'b1);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) rf_mem[i] = 8'($urandom);
      reset_in                 = 1'b1;
      bus.cmd_valid_in         = 1'b0;
      bus.cmd_matrix_select_in = 2'b00;
      bus.cmd_write_in         = 1'b0;
      bus.wr_data_in           = '0;
      bus.wr_valid_in          = 1'b0;
      bus.rd_ready_in          = 1'b0;
      bus.tensor_core_busy_in  = 1'b0;
      #1;
      check("rst_cmd_ready", bus.cmd_ready_out, 1);
      check("rst_busy", bus.busy_out, 0);
      check("rst_done", bus.done_out, 0);
      check("rst_error", bus.error_out, 0);
      check("rst_we", bus.rf_write_enable_out, 0);
      check("rst_wr_ready", bus.wr_ready_out, 0);
      check("rst_rd_valid", bus.rd_valid_out, 0);
      check("rst_wr_addr", bus.rf_write_address_out, 0);
      check("rst_rd_addr", bus.rf_read_address_out, 0);
      next_cycle();
      next_cycle();
      reset_in = 1'b0;

      write_burst(0, 1, 1);
      read_burst(1, 1);
      write_burst(2, 2, 8'h21);
      illegal_burst();

      // Asynchronous reset after four of nine writes.
      issue(0, 1'b1);
      for (int k = 0; k < 4; k++) begin
         bus.wr_valid_in = 1'b1;
         bus.wr_data_in  = 8'(8'h40 + k);
         #1;
         check("pre_rst_we", bus.rf_write_enable_out, 1);
         check("pre_rst_addr", bus.rf_write_address_out, 32'(exp_addr(0, k)));
         rf_mem[exp_addr(0, k)] = bus.wr_data_in;
         next_cycle();
      end
      bus.wr_data_in = 8'h44;
      #1;
      reset_in = 1'b1;
      #1;
      check("async_rst_we", bus.rf_write_enable_out, 0);
      check("async_rst_busy", bus.busy_out, 0);
      check("async_rst_ready", bus.cmd_ready_out, 1);
      check("async_rst_wr_ready", bus.wr_ready_out, 0);
      next_cycle();
      check("held_rst_we", bus.rf_write_enable_out, 0);
      bus.wr_valid_in = 1'b0;
      reset_in        = 1'b0;
      write_burst(0, 1, 8'h60);

      for (int t = 0; t < 12; t++) begin
         int sel = int'($urandom_range(0, 3));
         if (sel == 3) illegal_burst();
         else if ($urandom_range(0, 1) == 1) write_burst(sel, 0, 0);
         else read_burst(sel, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
